// File: rtl/tfe_pkg.sv
// rtl/tfe_pkg.sv - shared state encoding and defaults for the TensorFlowE job path
package tfe_pkg;

    localparam int TFE_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_READ  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_OUT   = 3'd6
    } tfe_state_e;

    function automatic int tfe_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tfe_down_counter.sv
// rtl/tfe_down_counter.sv - loadable saturating down counter with zero flag
module tfe_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // load has priority; decrement stops at zero so the count never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tfe_job_sequencer.sv
// rtl/tfe_job_sequencer.sv - job controller: clear, load operands, accumulate, read, return result
module tfe_job_sequencer
    import tfe_pkg::*;
#(
    parameter int DATA_W     = TFE_DATA_W,
    parameter int MAX_LEN    = 16,
    parameter int LEN_W      = 5,
    parameter int ACC_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] core_data,
    output logic              core_wr,
    output logic              core_rd,
    output logic              core_clear,
    output logic              core_acc,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_vld
);

    localparam int CNT_W = $clog2(tfe_max(ACC_CYCLES, TIMEOUT) + 1);

    tfe_state_e state;
    tfe_state_e state_next;

    logic              beat;
    logic              len_ok;
    logic [LEN_W-1:0]  len_m1;
    logic              beat_load;
    logic              beat_last;
    logic              cyc_load;
    logic              cyc_dec;
    logic [CNT_W-1:0]  cyc_load_val;
    logic              cyc_zero;

    logic [DATA_W-1:0] m_data_d;
    logic [DATA_W-1:0] core_data_d;
    logic              m_valid_d;
    logic              done_d;
    logic              err_d;
    logic              core_wr_d;
    logic              core_rd_d;
    logic              core_clear_d;
    logic              core_acc_d;

    assign s_ready = (state == ST_LOAD);
    assign busy    = (state != ST_IDLE);
    assign beat    = s_valid && s_ready;
    assign len_ok  = (len != '0) && (len <= LEN_W'(MAX_LEN));
    assign len_m1  = len - 1'b1;

    // Beat counter holds "beats remaining after this one", so zero marks the last beat.
    assign beat_load = (state == ST_IDLE) && start && len_ok;

    tfe_down_counter #(.W(LEN_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_load),
        .load_val (len_m1),
        .dec      (beat),
        .zero     (beat_last)
    );

    // One cycle counter serves ACCUM (accumulate window) and WAIT (result timeout).
    assign cyc_load     = ((state == ST_LOAD) && beat && beat_last) || (state == ST_READ);
    assign cyc_load_val = (state == ST_READ) ? CNT_W'(TIMEOUT - 1) : CNT_W'(ACC_CYCLES);
    assign cyc_dec      = (state == ST_ACCUM) || (state == ST_WAIT);

    tfe_down_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cyc_load),
        .load_val (cyc_load_val),
        .dec      (cyc_dec),
        .zero     (cyc_zero)
    );

    // State and registered outputs; reset drops every core control at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            m_data     <= '0;
            m_valid    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_data  <= '0;
            core_wr    <= 1'b0;
            core_rd    <= 1'b0;
            core_clear <= 1'b0;
            core_acc   <= 1'b0;
        end else begin
            state      <= state_next;
            m_data     <= m_data_d;
            m_valid    <= m_valid_d;
            done       <= done_d;
            err        <= err_d;
            core_data  <= core_data_d;
            core_wr    <= core_wr_d;
            core_rd    <= core_rd_d;
            core_clear <= core_clear_d;
            core_acc   <= core_acc_d;
        end
    end

    // Next-state selection for the job phases.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start && len_ok) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_LOAD;
            ST_LOAD:  if (beat && beat_last) state_next = ST_ACCUM;
            ST_ACCUM: if (cyc_zero) state_next = ST_READ;
            ST_READ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (core_vld) begin
                    state_next = ST_OUT;
                end else if (cyc_zero) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OUT:   if (m_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the first ACCUM cycle carries the last write, so core_acc starts one cycle later.
    always_comb begin
        core_clear_d = (state_next == ST_CLEAR);
        core_rd_d    = (state_next == ST_READ);
        core_acc_d   = (state == ST_ACCUM) && !cyc_zero;
        core_wr_d    = beat;
        core_data_d  = beat ? s_data : core_data;
        m_valid_d    = m_valid;
        m_data_d     = m_data;
        done_d       = 1'b0;
        err_d        = err;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        err_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (core_vld) begin
                    m_valid_d = 1'b1;
                    m_data_d  = core_dout;
                end else if (cyc_zero) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
